// File: rtl/twiddle_sequencer_if.sv
// Twiddle stream bus: one beat of LANES twiddles with address/stage/butterfly tags.
interface twiddle_sequencer_if #(
    parameter int unsigned N     = 17,
    parameter int unsigned D     = 32,
    parameter int unsigned LANES = 1
);
    localparam int unsigned L = $clog2(D);

    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*N-1:0]   psi;
    logic [LANES*L-1:0]   tw_addr;
    logic [L-1:0]         stage;
    logic [L-2:0]         bf_idx;
    logic                 last;

    modport master (
        output out_valid, psi, tw_addr, stage, bf_idx, last,
        input  out_ready
    );

    modport slave (
        input  out_valid, psi, tw_addr, stage, bf_idx, last,
        output out_ready
    );
endinterface

// File: rtl/twiddle_sequencer.sv
// Streams the twiddle factors of a full D-point negacyclic NTT (forward CT) or
// INTT (inverse GS), LANES per beat, walking every stage and butterfly group.
// Tables hold psi^bitrev(i) and psi^-bitrev(i) mod Q, psi a primitive 2D-th root
// of unity derived from generator G of Z_Q*.
module twiddle_sequencer #(
    parameter int unsigned N     = 17,
    parameter int unsigned D     = 32,
    parameter int unsigned LANES = 1,
    parameter int unsigned Q     = 65537,
    parameter int unsigned G     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic inv,
    output logic busy,
    output logic done,
    twiddle_sequencer_if.master tw
);
    localparam int unsigned L    = $clog2(D);
    localparam int unsigned JW   = L - 1;
    localparam int unsigned HALF = D / 2;

    // Modular exponentiation by square-and-multiply, elaboration time only.
    function automatic logic [63:0] mod_pow(input logic [63:0] base, input logic [63:0] e);
        logic [63:0] r;
        logic [63:0] b;
        r = 64'd1;
        b = base % 64'(Q);
        for (int unsigned i = 0; i < 64; i++) begin
            if (e[i]) r = (r * b) % 64'(Q);
            b = (b * b) % 64'(Q);
        end
        return r;
    endfunction

    // Table in bit-reversed order: entry bitrev(k) holds root^k.
    function automatic logic [D*N-1:0] build_table(input logic [63:0] root);
        logic [D*N-1:0] t;
        logic [63:0]    acc;
        int unsigned    rev;
        t   = '0;
        acc = 64'd1;
        for (int unsigned k = 0; k < D; k++) begin
            rev = 0;
            for (int unsigned b = 0; b < L; b++) begin
                if (k[b]) rev[L-1-b] = 1'b1;
            end
            t[rev*N +: N] = N'(acc);
            acc = (acc * root) % 64'(Q);
        end
        return t;
    endfunction

    localparam logic [63:0]    PSI_ROOT      = mod_pow(64'(G), 64'((Q - 1) / (2 * D)));
    localparam logic [63:0]    PSI_INV_ROOT  = mod_pow(PSI_ROOT, 64'(2 * D - 1));
    localparam logic [D*N-1:0] PSI_TABLE     = build_table(PSI_ROOT);
    localparam logic [D*N-1:0] PSI_INV_TABLE = build_table(PSI_INV_ROOT);
    localparam logic [JW-1:0]  J_LAST        = JW'(HALF - LANES);
    localparam logic [L-1:0]   S_LAST        = L'(L - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_n;
    logic [L-1:0]       s_q, s_n;
    logic [JW-1:0]      j_q, j_n;
    logic               inv_q, inv_n;
    logic               valid_q, valid_n;
    logic               last_q, last_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic               load;
    logic [LANES*L-1:0] addr_q, addr_n;
    logic [LANES*N-1:0] psi_q, psi_n;
    logic [L-1:0]       jk_c;
    logic [L-1:0]       a_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    // Next-state, beat counters and control outputs.
    always_comb begin
        state_n = state_q;
        s_n     = s_q;
        j_n     = j_q;
        inv_n   = inv_q;
        valid_n = valid_q;
        last_n  = last_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                busy_n = 1'b0;
                if (start) begin
                    state_n = RUN;
                    inv_n   = inv;
                    s_n     = '0;
                    j_n     = '0;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (valid_q && tw.out_ready) begin
                    if (last_q) begin
                        state_n = DONE;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        load = 1'b1;
                        if (j_q == J_LAST) begin
                            j_n = '0;
                            s_n = s_q + L'(1);
                        end else begin
                            j_n = j_q + JW'(LANES);
                        end
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
        if (load) last_n = (s_n == S_LAST) && (j_n == J_LAST);
    end

    // Per-lane table address and twiddle lookup for the upcoming beat.
    always_comb begin
        addr_n = '0;
        psi_n  = '0;
        jk_c   = '0;
        a_c    = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            jk_c = L'(j_n) + L'(k);
            if (inv_n) a_c = L'(D >> (s_n + L'(1))) + (jk_c >> s_n);
            else       a_c = (L'(1) << s_n) + (jk_c >> (S_LAST - s_n));
            addr_n[k*L +: L] = a_c;
            psi_n[k*N +: N]  = inv_n ? PSI_INV_TABLE[a_c*N +: N] : PSI_TABLE[a_c*N +: N];
        end
    end

    // Beat and control registers; beat payload only changes on load so stalls hold it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            j_q     <= '0;
            inv_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            psi_q   <= '0;
        end else begin
            s_q     <= s_n;
            j_q     <= j_n;
            inv_q   <= inv_n;
            valid_q <= valid_n;
            last_q  <= last_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            if (load) begin
                addr_q <= addr_n;
                psi_q  <= psi_n;
            end
        end
    end

    assign tw.out_valid = valid_q;
    assign tw.psi       = psi_q;
    assign tw.tw_addr   = addr_q;
    assign tw.stage     = s_q;
    assign tw.bf_idx    = j_q;
    assign tw.last      = last_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_twiddle_sequencer.sv
// Bench for twiddle_sequencer: two instances (LANES=1 and LANES=2) driven one at a
// time and compared beat by beat against a queue of expected beats.
module tb_twiddle_sequencer;
    localparam int unsigned N = 17;
    localparam int unsigned D = 32;
    localparam int unsigned L = $clog2(D);
    localparam int unsigned Q = 65537;
    localparam int unsigned G = 3;

    typedef struct {
        int              stage;
        int              j;
        bit              last;
        logic [2*L-1:0]  addr;
        logic [2*N-1:0]  psi;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_in, inv_in, ready_in, sel;
    logic start1, start2, busy1, busy2, done1, done2;

    twiddle_sequencer_if #(.N(N), .D(D), .LANES(1)) if1 ();
    twiddle_sequencer_if #(.N(N), .D(D), .LANES(2)) if2 ();

    assign start1 = start_in & ~sel;
    assign start2 = start_in & sel;
    assign if1.out_ready = ready_in;
    assign if2.out_ready = ready_in;

    twiddle_sequencer #(.N(N), .D(D), .LANES(1), .Q(Q), .G(G)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .inv(inv_in),
        .busy(busy1), .done(done1), .tw(if1)
    );
    twiddle_sequencer #(.N(N), .D(D), .LANES(2), .Q(Q), .G(G)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .inv(inv_in),
        .busy(busy2), .done(done2), .tw(if2)
    );

    logic           o_valid, o_last, o_busy, o_done;
    logic [2*N-1:0] o_psi;
    logic [2*L-1:0] o_addr;
    logic [L-1:0]   o_stage;
    logic [L-2:0]   o_bf;

    always_comb begin
        if (sel) begin
            o_valid = if2.out_valid; o_psi = if2.psi; o_addr = if2.tw_addr;
            o_stage = if2.stage; o_bf = if2.bf_idx; o_last = if2.last;
            o_busy = busy2; o_done = done2;
        end else begin
            o_valid = if1.out_valid; o_psi = (2*N)'(if1.psi); o_addr = (2*L)'(if1.tw_addr);
            o_stage = if1.stage; o_bf = if1.bf_idx; o_last = if1.last;
            o_busy = busy1; o_done = done1;
        end
    end

    int    n_assert = 0;
    int    n_fail   = 0;
    longint root;
    beat_t exp_q[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] expv);
        n_assert++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic longint powmod(input longint b, input int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % longint'(Q);
        return r;
    endfunction

    function automatic int bitrev(input int a);
        int r = 0;
        for (int b = 0; b < int'(L); b++) if (((a >> b) & 1) != 0) r = r | (1 << (int'(L) - 1 - b));
        return r;
    endfunction

    // Expected beats: stage tables start at 2^s (forward) or D/2^(s+1) (inverse),
    // the group index being the butterfly divided by the group span.
    function automatic void build(input int lanes, input bit iv);
        beat_t b;
        int jk, a, e, span;
        longint p;
        exp_q.delete();
        for (int s = 0; s < int'(L); s++) begin
            for (int j = 0; j < int'(D) / 2; j += lanes) begin
                b.stage = s; b.j = j;
                b.last  = (s == int'(L) - 1) && (j == int'(D) / 2 - lanes);
                b.addr  = '0; b.psi = '0;
                for (int k = 0; k < lanes; k++) begin
                    jk = j + k;
                    if (iv) begin span = 2 ** s;            a = int'(D) / (2 ** (s + 1)) + jk / span; end
                    else    begin span = (int'(D) / 2) / (2 ** s); a = 2 ** s + jk / span; end
                    e = bitrev(a);
                    p = iv ? powmod(root, (2 * int'(D) - e) % (2 * int'(D))) : powmod(root, e);
                    b.addr[k*L +: L] = L'(a);
                    b.psi[k*N +: N]  = N'(p);
                end
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic run_stream(input bit s2, input bit iv, input bit rnd,
                              input int restart_at, input int rst_at);
        int lanes, beats, cyc, nexp;
        bit acc;
        beat_t h;
        lanes = s2 ? 2 : 1;
        sel = s2;
        build(lanes, iv);
        nexp = int'(L) * int'(D) / (2 * lanes);
        ready_in = 1'b1; inv_in = iv; start_in = 1'b1;
        tick;
        start_in = 1'b0;
        cyc = 1; beats = 0;
        forever begin
            if (cyc > 1000) begin chk("timeout", 1, 0); return; end
            if (rst_at >= 0 && beats == rst_at) begin
                rst = 1'b1;
                tick;
                rst = 1'b0;
                chk("rst_mid", {o_valid, o_busy, o_done, o_stage, o_bf, o_last, o_addr, o_psi}, 0);
                return;
            end
            h = exp_q[0];
            chk("beat", {o_valid, o_busy, o_done, o_stage, o_bf, o_last, o_addr, o_psi},
                {1'b1, 1'b1, 1'b0, L'(h.stage), (L-1)'(h.j), h.last, h.addr, h.psi});
            if (s2 && !iv && h.stage == 4 && h.j == 6) chk("l2_s4_j6", o_addr, {5'd23, 5'd22});
            if (!s2 && !iv && h.stage == 0) chk("fwd_s0", o_addr, 1);
            if (!s2 && !iv && h.stage == 1) chk("fwd_s1", o_addr, (h.j < 8) ? 2 : 3);
            if (!s2 && iv && h.stage == 0) chk("inv_s0", o_addr, 16 + h.j);
            if (!s2 && iv && h.stage == 4) chk("inv_s4", o_addr, 1);
            start_in = (restart_at >= 0 && beats == restart_at);
            inv_in   = start_in ? 1'b1 : (rnd ? 1'($urandom_range(0, 1)) : iv);
            ready_in = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
            acc = o_valid && ready_in;
            tick;
            cyc++;
            start_in = 1'b0;
            if (acc) begin
                void'(exp_q.pop_front());
                beats++;
                if (h.last) break;
            end
        end
        ready_in = 1'b1;
        chk("done_pulse", {o_valid, o_done, o_busy}, 3'b011);
        chk("beat_total", beats, nexp);
        if (!rnd) chk("done_cycle", cyc, nexp + 1);
        tick;
        chk("idle_after", {o_valid, o_done, o_busy}, 0);
        tick;
        chk("no_2nd_done", {o_valid, o_done, o_busy}, 0);
    endtask

    initial begin
        rst = 1'b1; start_in = 1'b0; inv_in = 1'b0; ready_in = 1'b0; sel = 1'b0;
        root = powmod(longint'(G), int'((Q - 1) / (2 * D)));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset", {o_valid, o_busy, o_done, o_stage, o_bf, o_last, o_addr, o_psi}, 0);
        rst = 1'b0;
        ready_in = 1'b1;
        tick;
        chk("idle_ready_hi", {o_valid, o_busy, o_done}, 0);
        run_stream(1'b0, 1'b0, 1'b0, -1, -1);   // forward, LANES=1
        run_stream(1'b0, 1'b1, 1'b0, -1, -1);   // inverse, LANES=1
        run_stream(1'b1, 1'b0, 1'b0, -1, -1);   // forward, LANES=2
        run_stream(1'b1, 1'b1, 1'b1, -1, -1);   // inverse, LANES=2, random stalls
        run_stream(1'b0, 1'b0, 1'b1, -1, -1);   // forward, random stalls, inv toggling
        run_stream(1'b0, 1'b0, 1'b0, 10, -1);   // start re-pulsed mid-stream
        run_stream(1'b0, 1'b0, 1'b0, -1, 20);   // reset mid-stream
        tick;
        chk("post_rst_idle", {o_valid, o_busy, o_done}, 0);
        run_stream(1'b0, 1'b0, 1'b0, -1, -1);   // clean restart after reset
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
